// File: rtl/wb_uart_lite_if.sv
// wb_uart_lite_if: Wishbone classic data-bus bundle between a CPU-side master and the UART slave.
//   master: drives cyc/stb/we/adr/sel/dat_i, receives dat_o/ack
//   slave : receives cyc/stb/we/adr/sel/dat_i, drives dat_o/ack
interface wb_uart_lite_if;
  logic        wb_cyc_i;
  logic        wb_stb_i;
  logic        wb_we_i;
  logic [31:0] wb_adr_i;
  logic [3:0]  wb_sel_i;
  logic [31:0] wb_dat_i;
  logic [31:0] wb_dat_o;
  logic        wb_ack_o;
  modport master (output wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_sel_i, wb_dat_i, input wb_dat_o, wb_ack_o);
  modport slave  (input wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_sel_i, wb_dat_i, output wb_dat_o, wb_ack_o);
endinterface

// File: rtl/wb_uart_lite.sv
// wb_uart_lite: Wishbone slave UART with TX FIFO, one-byte RX holding register and level interrupt.
//   wb_clk_i/wb_rst_i : clock, synchronous active-high reset
//   bus               : Wishbone slave port (adr[3:2]: 0 DATA, 1 STATUS, 2 DIV, 3 CTRL)
//   uart_rx_i         : asynchronous serial input, idle high
//   uart_tx_o         : serial output, idle high
//   uart_int_o        : registered level interrupt
//   Define UART_LOOPBACK_EN to add CTRL bit2 internal loopback.
module wb_uart_lite #(
  parameter int TX_DEPTH  = 8,
  parameter int DIV_RESET = 433
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_i,
  wb_uart_lite_if.slave bus,
  input  logic          uart_rx_i,
  output logic          uart_tx_o,
  output logic          uart_int_o
);
  localparam int AW = $clog2(TX_DEPTH);
`ifdef UART_LOOPBACK_EN
  localparam logic LB = 1'b1;
`else
  localparam logic LB = 1'b0;
`endif
  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;
  logic ack_q, ack_d, tx_q, tx_d, rx_valid_q, rx_valid_d, ovr_q, ovr_d, ferr_q, ferr_d, int_q, int_d;
  logic [15:0] div_q, div_d, tx_tmr_q, tx_tmr_d, rx_tmr_q, rx_tmr_d, rx_half;
  logic [2:0] ctrl_q, ctrl_d, tx_bit_q, tx_bit_d, rx_bit_q, rx_bit_d, sync_q, sync_d;
  logic [7:0] tx_sh_q, tx_sh_d, rx_sh_q, rx_sh_d, rx_byte_q, rx_byte_d;
  logic [7:0] fifo_q [TX_DEPTH];
  logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [AW:0] cnt_q, cnt_d;
  state_e tx_st_q, tx_st_d, rx_st_q, rx_st_d;
  logic acc, wr, rd, st_rd, push, pop, full, empty, tx_idle, rx_in, rx_done, keep;
  logic [1:0] a;
  logic [31:0] rdata;
  logic unused_ok;
  assign a = bus.wb_adr_i[3:2];
  // side effects fire in the ack cycle, while the master still holds the request
  assign acc = ack_q & bus.wb_cyc_i & bus.wb_stb_i;
  assign wr = acc & bus.wb_we_i;
  assign rd = acc & ~bus.wb_we_i;
  assign st_rd = rd & (a == 2'd1);
  assign full = cnt_q[AW];
  assign empty = cnt_q == '0;
  assign push = wr & (a == 2'd0) & bus.wb_sel_i[0] & ~full;
  assign tx_idle = (tx_st_q == S_IDLE) & empty;
  assign rx_in = sync_q[1];
  // start-bit recheck delay of (DIV+1)/2 clocks, expressed as a down-counter load
  assign rx_half = (div_q >> 1) - {15'd0, ~div_q[0] & (div_q != 16'd0)};
  // holding register still occupied after any pop in this cycle
  assign keep = rx_valid_q & ~(rd & (a == 2'd0));
  assign sync_d = {sync_q[1:0], ctrl_q[2] ? tx_q : uart_rx_i};
  assign rdata = a == 2'd0 ? {24'd0, rx_valid_q ? rx_byte_q : 8'd0} :
                 a == 2'd1 ? {26'd0, ferr_q, tx_idle, ovr_q, empty, full, rx_valid_q} :
                 a == 2'd2 ? {16'd0, div_q} : {29'd0, ctrl_q};
  assign bus.wb_ack_o = ack_q;
  assign bus.wb_dat_o = ack_q ? rdata : '0;
  assign uart_tx_o = tx_q | ctrl_q[2];
  assign uart_int_o = int_q;
  assign unused_ok = ^{bus.wb_adr_i[31:4], bus.wb_adr_i[1:0], bus.wb_sel_i[3:2], bus.wb_dat_i[31:16]};
  always_comb begin
    ack_d = bus.wb_cyc_i & bus.wb_stb_i & ~ack_q;
    div_d = (wr && a == 2'd2) ? {bus.wb_sel_i[1] ? bus.wb_dat_i[15:8] : div_q[15:8],
                                 bus.wb_sel_i[0] ? bus.wb_dat_i[7:0] : div_q[7:0]} : div_q;
    ctrl_d = (wr && a == 2'd3 && bus.wb_sel_i[0]) ? {LB & bus.wb_dat_i[2], bus.wb_dat_i[1:0]} : ctrl_q;
    wp_d = push ? wp_q + AW'(1) : wp_q;
    rp_d = pop ? rp_q + AW'(1) : rp_q;
    cnt_d = cnt_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    rx_valid_d = keep | (rx_done & rx_in);
    rx_byte_d = (rx_done & rx_in & ~keep) ? rx_sh_q : rx_byte_q;
    ovr_d = (ovr_q & ~st_rd) | (rx_done & rx_in & keep);
    ferr_d = (ferr_q & ~st_rd) | (rx_done & ~rx_in);
    int_d = (ctrl_q[0] & rx_valid_q) | (ctrl_q[1] & tx_idle);
  end
  always_comb begin
    tx_st_d = tx_st_q;
    tx_tmr_d = tx_tmr_q - 16'd1;
    tx_bit_d = tx_bit_q;
    tx_sh_d = tx_sh_q;
    tx_d = tx_q;
    pop = 1'b0;
    if (tx_st_q == S_IDLE || (tx_st_q == S_STOP && tx_tmr_q == 16'd0)) begin
      tx_st_d = S_IDLE;
      tx_tmr_d = div_q;
      tx_d = 1'b1;
      if (!empty) begin
        pop = 1'b1;
        tx_st_d = S_START;
        tx_sh_d = fifo_q[rp_q];
        tx_d = 1'b0;
      end
    end else if (tx_tmr_q == 16'd0) begin
      tx_tmr_d = div_q;
      if (tx_st_q == S_START) begin
        tx_st_d = S_DATA;
        tx_bit_d = 3'd0;
        tx_d = tx_sh_q[0];
      end else if (tx_bit_q == 3'd7) begin
        tx_st_d = S_STOP;
        tx_d = 1'b1;
      end else begin
        tx_bit_d = tx_bit_q + 3'd1;
        tx_sh_d = tx_sh_q >> 1;
        tx_d = tx_sh_q[1];
      end
    end
  end
  always_comb begin
    rx_st_d = rx_st_q;
    rx_tmr_d = rx_tmr_q - 16'd1;
    rx_bit_d = rx_bit_q;
    rx_sh_d = rx_sh_q;
    rx_done = 1'b0;
    case (rx_st_q)
      S_IDLE: begin
        rx_tmr_d = rx_half;
        if (sync_q[2] & ~sync_q[1]) rx_st_d = S_START;
      end
      S_START: if (rx_tmr_q == 16'd0) begin
        rx_tmr_d = div_q;
        rx_bit_d = 3'd0;
        rx_st_d = rx_in ? S_IDLE : S_DATA;
      end
      S_DATA: if (rx_tmr_q == 16'd0) begin
        rx_tmr_d = div_q;
        rx_sh_d = {rx_in, rx_sh_q[7:1]};
        rx_bit_d = rx_bit_q + 3'd1;
        if (rx_bit_q == 3'd7) rx_st_d = S_STOP;
      end
      default: if (rx_tmr_q == 16'd0) begin
        rx_st_d = S_IDLE;
        rx_done = 1'b1;
      end
    endcase
  end
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      ack_q <= 1'b0;
      div_q <= 16'(DIV_RESET);
      ctrl_q <= '0;
      wp_q <= '0;
      rp_q <= '0;
      cnt_q <= '0;
      tx_st_q <= S_IDLE;
      tx_tmr_q <= '0;
      tx_bit_q <= '0;
      tx_sh_q <= '0;
      tx_q <= 1'b1;
      sync_q <= 3'b111;
      rx_st_q <= S_IDLE;
      rx_tmr_q <= '0;
      rx_bit_q <= '0;
      rx_sh_q <= '0;
      rx_byte_q <= '0;
      rx_valid_q <= 1'b0;
      ovr_q <= 1'b0;
      ferr_q <= 1'b0;
      int_q <= 1'b0;
    end else begin
      ack_q <= ack_d;
      div_q <= div_d;
      ctrl_q <= ctrl_d;
      wp_q <= wp_d;
      rp_q <= rp_d;
      cnt_q <= cnt_d;
      tx_st_q <= tx_st_d;
      tx_tmr_q <= tx_tmr_d;
      tx_bit_q <= tx_bit_d;
      tx_sh_q <= tx_sh_d;
      tx_q <= tx_d;
      sync_q <= sync_d;
      rx_st_q <= rx_st_d;
      rx_tmr_q <= rx_tmr_d;
      rx_bit_q <= rx_bit_d;
      rx_sh_q <= rx_sh_d;
      rx_byte_q <= rx_byte_d;
      rx_valid_q <= rx_valid_d;
      ovr_q <= ovr_d;
      ferr_q <= ferr_d;
      int_q <= int_d;
    end
  end
  always_ff @(posedge wb_clk_i) begin
    if (push) fifo_q[wp_q] <= bus.wb_dat_i[7:0];
  end
endmodule

// File: tb/tb_wb_uart_lite.sv
// tb_wb_uart_lite: directed self-checking bench for wb_uart_lite.
module tb_wb_uart_lite;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx = 1'b1;
  logic tx, irq;
  int checks = 0;
  int errors = 0;
  longint cycles = 0;
  logic [7:0] txq[$];
  longint tst[$];
  logic txs[$];
`ifdef UART_LOOPBACK_EN
  localparam logic [31:0] CTRL_RB = 32'h7;
`else
  localparam logic [31:0] CTRL_RB = 32'h3;
`endif
  wb_uart_lite_if bus();
  wb_uart_lite dut (.wb_clk_i(clk), .wb_rst_i(rst), .bus(bus), .uart_rx_i(rx), .uart_tx_o(tx), .uart_int_o(irq));
  always #5 clk = ~clk;
  always @(posedge clk) cycles <= cycles + 1;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got 0x%0h exp 0x%0h", tag, got, exp);
    end
  endtask
  task automatic wb(input logic w, input logic [1:0] idx, input logic [31:0] d, output logic [31:0] r);
    int n = 0;
    @(negedge clk);
    bus.wb_cyc_i = 1'b1;
    bus.wb_stb_i = 1'b1;
    bus.wb_we_i = w;
    bus.wb_adr_i = {28'd0, idx, 2'b00};
    bus.wb_sel_i = 4'hF;
    bus.wb_dat_i = d;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!bus.wb_ack_o && n < 8);
    check("ack_latency", n, 1);
    r = bus.wb_dat_o;
    @(posedge clk); #1;
    bus.wb_cyc_i = 1'b0;
    bus.wb_stb_i = 1'b0;
    bus.wb_we_i = 1'b0;
    check("ack_width", {31'd0, bus.wb_ack_o}, 0);
  endtask
  task automatic wr(input logic [1:0] idx, input logic [31:0] d);
    logic [31:0] r;
    wb(1'b1, idx, d, r);
  endtask
  task automatic rd_chk(input string tag, input logic [1:0] idx, input logic [31:0] exp);
    logic [31:0] r;
    wb(1'b0, idx, 32'd0, r);
    check(tag, r, exp);
  endtask
  task automatic wait_tx(input int n);
    int k = 0;
    while (txq.size() < n && k < 3000) begin
      @(posedge clk);
      k++;
    end
    check("tx_frames", txq.size(), n);
  endtask
  task automatic send_rx(input logic [7:0] b, input logic stop);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      rx = f[i];
      repeat (3) @(negedge clk);
    end
  endtask
  task automatic rx_idle(input int n);
    @(negedge clk);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  // TX line monitor: mid-bit sampling assuming a 4-clock bit period
  initial begin : mon
    logic [7:0] b;
    logic s;
    longint t;
    forever begin
      @(posedge clk); #1;
      if (!rst && tx === 1'b0) begin
        t = cycles;
        b = '0;
        @(posedge clk); #1;
        for (int k = 0; k < 8; k++) begin
          repeat (4) @(posedge clk);
          #1;
          b[k] = tx;
        end
        repeat (4) @(posedge clk);
        #1;
        s = tx;
        txq.push_back(b);
        tst.push_back(t);
        txs.push_back(s);
      end
    end
  end
  initial begin : watchdog
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
  initial begin
    int zeros;
    bus.wb_cyc_i = 1'b0;
    bus.wb_stb_i = 1'b0;
    bus.wb_we_i = 1'b0;
    bus.wb_adr_i = '0;
    bus.wb_sel_i = '0;
    bus.wb_dat_i = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_tx", {31'd0, tx}, 1);
    check("rst_int", {31'd0, irq}, 0);
    check("rst_ack", {31'd0, bus.wb_ack_o}, 0);
    check("rst_dat", bus.wb_dat_o, 0);
    @(negedge clk);
    rst = 1'b0;
    rd_chk("rst_data", 2'd0, 32'h0);
    rd_chk("rst_status", 2'd1, 32'h14);
    rd_chk("rst_div", 2'd2, 32'd433);
    rd_chk("rst_ctrl", 2'd3, 32'h0);
    wr(2'd2, 32'd3);
    rd_chk("div_rb", 2'd2, 32'd3);
    wr(2'd0, 32'h55);
    wait_tx(1);
    check("tx55_byte", {24'd0, txq[0]}, 32'h55);
    check("tx55_stop", {31'd0, txs[0]}, 1);
    idle(6);
    rd_chk("tx55_status", 2'd1, 32'h14);
    txq.delete();
    tst.delete();
    txs.delete();
    for (int i = 1; i <= 9; i++) wr(2'd0, i);
    rd_chk("burst_full", 2'd1, 32'h02);
    wr(2'd0, 32'h0A);
    wait_tx(9);
    for (int i = 0; i < 9; i++) begin
      check("burst_byte", {24'd0, txq[i]}, i + 1);
      check("burst_stop", {31'd0, txs[i]}, 1);
      if (i > 0) check("burst_gap", 32'(tst[i] - tst[i-1]), 40);
    end
    idle(80);
    check("burst_drop", txq.size(), 9);
    rd_chk("burst_end", 2'd1, 32'h14);
    wr(2'd3, 32'h7);
    rd_chk("ctrl_rb", 2'd3, CTRL_RB);
    idle(3);
    check("txint_on", {31'd0, irq}, 1);
    wr(2'd3, 32'h0);
    idle(3);
    check("txint_off", {31'd0, irq}, 0);
    send_rx(8'hA3, 1'b1);
    send_rx(8'h5C, 1'b1);
    rx_idle(8);
    rd_chk("ovr_data", 2'd0, 32'hA3);
    rd_chk("ovr_status", 2'd1, 32'h1C);
    rd_chk("ovr_clear", 2'd1, 32'h14);
    rd_chk("empty_data", 2'd0, 32'h0);
    wr(2'd3, 32'h1);
    send_rx(8'h7E, 1'b0);
    rx_idle(8);
    idle(2);
    check("ferr_int", {31'd0, irq}, 0);
    rd_chk("ferr_status", 2'd1, 32'h34);
    rd_chk("ferr_clear", 2'd1, 32'h14);
    send_rx(8'h7E, 1'b1);
    rx_idle(8);
    idle(2);
    check("rxint_on", {31'd0, irq}, 1);
    rd_chk("rx_data", 2'd0, 32'h7E);
    idle(3);
    check("rxint_off", {31'd0, irq}, 0);
`ifdef UART_LOOPBACK_EN
    wr(2'd3, 32'h5);
    wr(2'd0, 32'hC3);
    zeros = 0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #1;
      if (tx !== 1'b1) zeros++;
    end
    check("lb_tx_quiet", zeros, 0);
    check("lb_int", {31'd0, irq}, 1);
    rd_chk("lb_data", 2'd0, 32'hC3);
    wr(2'd3, 32'h0);
`else
    zeros = 0;
`endif
    wr(2'd0, 32'h00);
    idle(10);
    check("pre_reset_tx", {31'd0, tx}, 0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check("midrst_tx", {31'd0, tx}, 1);
    @(negedge clk);
    rst = 1'b0;
    rd_chk("midrst_status", 2'd1, 32'h14);
    rd_chk("midrst_div", 2'd2, 32'd433);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
